// File: rtl/spi_apb_pkg.sv
// Shared constants and types for the SPI APB register file: register map,
// write masks, reset values, status-register bit positions and APB FSM states.
package spi_apb_pkg;

  localparam logic [2:0] ADDR_CR1 = 3'd0;
  localparam logic [2:0] ADDR_CR2 = 3'd1;
  localparam logic [2:0] ADDR_BR  = 3'd2;
  localparam logic [2:0] ADDR_SR  = 3'd3;
  localparam logic [2:0] ADDR_DR  = 3'd5;

  localparam logic [7:0] CR1_MASK = 8'hFF;
  localparam logic [7:0] CR2_MASK = 8'h1B;
  localparam logic [7:0] BR_MASK  = 8'h77;

  localparam logic [7:0] CR1_RST = 8'h04;
  localparam logic [7:0] CR2_RST = 8'h00;
  localparam logic [7:0] BR_RST  = 8'h00;

  localparam int SR_SPIF    = 7;
  localparam int SR_SPTEF   = 5;
  localparam int SR_MODF    = 4;
  localparam int SR_RXOVF   = 3;
  localparam int SR_TXEMPTY = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ENABLE = 2'b10
  } apb_state_e;

  // Assemble the status register; unused positions read as zero.
  function automatic logic [7:0] sr_pack(input logic spif, input logic sptef,
                                         input logic modf, input logic rxovf,
                                         input logic txempty);
    logic [7:0] sr;
    sr = 8'h00;
    sr[SR_SPIF]    = spif;
    sr[SR_SPTEF]   = sptef;
    sr[SR_MODF]    = modf;
    sr[SR_RXOVF]   = rxovf;
    sr[SR_TXEMPTY] = txempty;
    return sr;
  endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO used for the SPI TX and RX paths. A push into a full FIFO
// is accepted only when a pop of the head happens in the same cycle; a pop on
// an empty FIFO is ignored.
module spi_sync_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              push,
  input  logic                              pop,
  input  logic [DATA_W-1:0]                 wdata,
  output logic [DATA_W-1:0]                 rdata,
  output logic                              full,
  output logic                              empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              do_push_s;
  logic              do_pop_s;

  assign full  = (count_r == DEPTH_C);
  assign empty = (count_r == {CW{1'b0}});
  assign count = count_r;
  assign rdata = mem_r[rd_ptr_r];

  // Qualify push/pop against the occupancy seen at the start of the cycle.
  always_comb begin
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
  end

  // Storage array write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy tracking; power-of-two depth lets pointers wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/spi_apb_regfile_fifo.sv
// APB register file for the SPI controller with TX/RX FIFOs, sticky receive
// overflow and slave-error reporting. Optional feature macro: SPI_APB_IRQ_EN
// (interrupt request and rxovf status); without it the interrupt is tied low
// and overflowing frames are dropped silently.
module spi_apb_regfile_fifo
  import spi_apb_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              PClk,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [2:0]        PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_pop,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_push,
  input  logic              tip,
  input  logic              SS,
  output logic              mstr,
  output logic              cpol,
  output logic              cpha,
  output logic              lsbfe,
  output logic              spe,
  output logic              spiswai,
  output logic [2:0]        sppr,
  output logic [2:0]        spr,
  output logic              spi_interrupt_request
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  apb_state_e state_r;
  apb_state_e state_nxt_s;

  logic [7:0] cr1_r;
  logic [7:0] cr2_r;
  logic [7:0] br_r;

  logic              access_s;
  logic              err_s;
  logic              cr1_we_s;
  logic              cr2_we_s;
  logic              br_we_s;
  logic              sr_clr_s;
  logic              tx_push_s;
  logic              rx_pop_s;
  logic [DATA_W-1:0] rdata_s;

  logic              tx_full_s;
  logic              tx_empty_s;
  logic              rx_full_s;
  logic              rx_empty_s;
  logic [DATA_W-1:0] rx_head_s;
  logic [CW-1:0]     tx_count_s;
  logic [CW-1:0]     rx_count_s;

  logic       modf_s;
  logic       rxovf_s;
  logic [7:0] sr_s;

  spi_sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (PClk),
    .rst_n (PRESETn),
    .push  (tx_push_s),
    .pop   (tx_pop),
    .wdata (PWDATA),
    .rdata (tx_data),
    .full  (tx_full_s),
    .empty (tx_empty_s),
    .count (tx_count_s)
  );

  spi_sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (PClk),
    .rst_n (PRESETn),
    .push  (rx_push),
    .pop   (rx_pop_s),
    .wdata (rx_data),
    .rdata (rx_head_s),
    .full  (rx_full_s),
    .empty (rx_empty_s),
    .count (rx_count_s)
  );

  logic fifo_unused_s;
  assign fifo_unused_s = ^{tx_count_s, rx_count_s};

  assign tx_valid = ~tx_empty_s;
  assign access_s = (state_r == ST_ENABLE) & PSEL & PENABLE;
  assign PREADY   = (state_r == ST_ENABLE);
  assign PSLVERR  = err_s;
  assign PRDATA   = rdata_s;

  assign modf_s = ~SS & cr1_r[4] & cr2_r[4] & ~cr1_r[1];
  assign sr_s   = sr_pack(~rx_empty_s, ~tx_full_s, modf_s, rxovf_s, tx_empty_s);

  assign spe     = cr1_r[6];
  assign mstr    = cr1_r[4];
  assign cpol    = cr1_r[3];
  assign cpha    = cr1_r[2];
  assign lsbfe   = cr1_r[0];
  assign spiswai = cr2_r[1];
  assign sppr    = br_r[6:4];
  assign spr     = br_r[2:0];

  // APB phase tracking state register.
  always_ff @(posedge PClk or negedge PRESETn) begin
    if (!PRESETn) state_r <= ST_IDLE;
    else          state_r <= state_nxt_s;
  end

  // APB phase next-state logic.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (PSEL && !PENABLE) state_nxt_s = ST_SETUP;
        else                  state_nxt_s = ST_IDLE;
      end
      ST_SETUP:  state_nxt_s = ST_ENABLE;
      ST_ENABLE: begin
        if (PSEL && !PENABLE) state_nxt_s = ST_SETUP;
        else                  state_nxt_s = ST_IDLE;
      end
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Access decode: error policy, write strobes and read mux. Full/empty come
  // from registered FIFO state, so same-cycle core activity cannot mask an error.
  always_comb begin
    err_s     = 1'b0;
    cr1_we_s  = 1'b0;
    cr2_we_s  = 1'b0;
    br_we_s   = 1'b0;
    sr_clr_s  = 1'b0;
    tx_push_s = 1'b0;
    rx_pop_s  = 1'b0;
    rdata_s   = {DATA_W{1'b0}};
    if (access_s) begin
      case (PADDR)
        ADDR_CR1: begin
          if (PWRITE) begin
            if (tip) err_s = 1'b1;
            else     cr1_we_s = 1'b1;
          end else begin
            rdata_s = DATA_W'(cr1_r);
          end
        end
        ADDR_CR2: begin
          if (PWRITE) begin
            if (tip) err_s = 1'b1;
            else     cr2_we_s = 1'b1;
          end else begin
            rdata_s = DATA_W'(cr2_r);
          end
        end
        ADDR_BR: begin
          if (PWRITE) begin
            if (tip) err_s = 1'b1;
            else     br_we_s = 1'b1;
          end else begin
            rdata_s = DATA_W'(br_r);
          end
        end
        ADDR_SR: begin
          if (PWRITE) sr_clr_s = PWDATA[SR_RXOVF];
          else        rdata_s  = DATA_W'(sr_s);
        end
        ADDR_DR: begin
          if (PWRITE) begin
            if (tx_full_s) err_s     = 1'b1;
            else           tx_push_s = 1'b1;
          end else begin
            if (rx_empty_s) begin
              err_s = 1'b1;
            end else begin
              rdata_s  = rx_head_s;
              rx_pop_s = 1'b1;
            end
          end
        end
        default: err_s = 1'b1;
      endcase
    end else begin
      err_s = 1'b0;
    end
  end

  // Configuration registers, masked to their implemented bits.
  always_ff @(posedge PClk or negedge PRESETn) begin
    if (!PRESETn) begin
      cr1_r <= CR1_RST;
      cr2_r <= CR2_RST;
      br_r  <= BR_RST;
    end else begin
      if (cr1_we_s) cr1_r <= PWDATA[7:0] & CR1_MASK;
      if (cr2_we_s) cr2_r <= PWDATA[7:0] & CR2_MASK;
      if (br_we_s)  br_r  <= PWDATA[7:0] & BR_MASK;
    end
  end

`ifdef SPI_APB_IRQ_EN
  logic rxovf_r;
  logic ovf_set_s;

  // A frame is lost only if RX is full and no DR read frees a slot this cycle.
  assign ovf_set_s = rx_push & rx_full_s & ~rx_pop_s;

  // Sticky overflow flag; a new overflow wins over a same-cycle clear.
  always_ff @(posedge PClk or negedge PRESETn) begin
    if (!PRESETn)       rxovf_r <= 1'b0;
    else if (ovf_set_s) rxovf_r <= 1'b1;
    else if (sr_clr_s)  rxovf_r <= 1'b0;
    else                rxovf_r <= rxovf_r;
  end

  assign rxovf_s = rxovf_r;
  assign spi_interrupt_request = (cr1_r[7] & (sr_s[SR_SPIF] | sr_s[SR_MODF] | sr_s[SR_RXOVF]))
                               | (cr1_r[5] & sr_s[SR_SPTEF]);
`else
  logic irq_unused_s;
  assign irq_unused_s = ^{rx_full_s, sr_clr_s};
  assign rxovf_s = 1'b0;
  assign spi_interrupt_request = 1'b0;
`endif

endmodule

// File: tb/tb_spi_apb_regfile_fifo.sv
// Self-checking bench for spi_apb_regfile_fifo (DATA_W = 8, FIFO_DEPTH = 4):
// a vector table, hand-written corner sequences and a randomized phase
// checked against a queue-based transaction model.
module tb_spi_apb_regfile_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
`ifdef SPI_APB_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic          PClk = 1'b0;
  logic          PRESETn = 1'b0;
  logic          PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [2:0]    PADDR = 3'd0;
  logic [DW-1:0] PWDATA = '0;
  logic [DW-1:0] PRDATA;
  logic          PREADY, PSLVERR;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_pop = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          rx_push = 1'b0;
  logic          tip = 1'b0;
  logic          SS = 1'b1;
  logic          mstr, cpol, cpha, lsbfe, spe, spiswai;
  logic [2:0]    sppr, spr;
  logic          irq;

  spi_apb_regfile_fifo #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .PClk(PClk), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_pop(tx_pop), .rx_data(rx_data),
    .rx_push(rx_push), .tip(tip), .SS(SS), .mstr(mstr), .cpol(cpol), .cpha(cpha),
    .lsbfe(lsbfe), .spe(spe), .spiswai(spiswai), .sppr(sppr), .spr(spr),
    .spi_interrupt_request(irq)
  );

  always #5 PClk = ~PClk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // One APB transfer. Side-band core events (rx_push / tx_pop) are raised in
  // the completing cycle so they coincide with the commit edge.
  task automatic apb(input logic wr, input logic [2:0] a, input logic [DW-1:0] wd,
                     input logic sp, input logic st, input logic [DW-1:0] sd,
                     output logic [DW-1:0] rd, output logic er);
    bit got;
    got = 1'b0;
    rd = '0;
    er = 1'b0;
    @(posedge PClk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd;
    @(posedge PClk); #1;
    PENABLE = 1'b1;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge PClk);
      if (PREADY) begin
        got = 1'b1;
        rd = PRDATA;
        er = PSLVERR;
        rx_push = sp; tx_pop = st; rx_data = sd;
      end
    end
    chk("apb_pready", got, 1);
    @(posedge PClk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; rx_push = 1'b0; tx_pop = 1'b0;
  endtask

  task automatic apb_w(input string nm, input logic [2:0] a, input logic [DW-1:0] wd,
                       input logic eer);
    logic [DW-1:0] rd; logic er;
    apb(1'b1, a, wd, 1'b0, 1'b0, '0, rd, er);
    chk({nm, "_err"}, er, eer);
  endtask

  task automatic apb_r(input string nm, input logic [2:0] a, input logic [DW-1:0] erd,
                       input logic eer);
    logic [DW-1:0] rd; logic er;
    apb(1'b0, a, '0, 1'b0, 1'b0, '0, rd, er);
    chk({nm, "_rd"}, rd, erd);
    chk({nm, "_err"}, er, eer);
  endtask

  // Core-side cycle with no bus activity.
  task automatic cyc(input logic sp, input logic st, input logic [DW-1:0] sd);
    @(posedge PClk); #1;
    rx_push = sp; tx_pop = st; rx_data = sd;
    @(posedge PClk); #1;
    rx_push = 1'b0; tx_pop = 1'b0;
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] tx_q[$];
  logic [DW-1:0] rx_q[$];
  logic [7:0]    m_cr1, m_cr2, m_br;
  logic          m_ovf;

  function automatic void m_reset();
    tx_q.delete(); rx_q.delete();
    m_cr1 = 8'h04; m_cr2 = 8'h00; m_br = 8'h00; m_ovf = 1'b0;
  endfunction

  function automatic logic [7:0] m_sr();
    logic modf;
    modf = !SS && m_cr1[4] && m_cr2[4] && !m_cr1[1];
    return {rx_q.size() != 0, 1'b0, tx_q.size() < DEPTH, modf, m_ovf,
            tx_q.size() == 0, 2'b00};
  endfunction

  function automatic void m_step(input logic acc, input logic wr, input logic [2:0] a,
                                 input logic [DW-1:0] wd, input logic sp, input logic st,
                                 input logic [DW-1:0] sd,
                                 output logic [DW-1:0] erd, output logic eer);
    bit tx_full, rx_empty, do_push, rd_pop;
    tx_full = (tx_q.size() == DEPTH);
    rx_empty = (rx_q.size() == 0);
    do_push = 1'b0; rd_pop = 1'b0;
    erd = '0; eer = 1'b0;
    if (acc) begin
      case (a)
        3'd0: if (wr) begin if (tip) eer = 1'b1; else m_cr1 = wd[7:0]; end else erd = m_cr1;
        3'd1: if (wr) begin if (tip) eer = 1'b1; else m_cr2 = wd[7:0] & 8'h1B; end else erd = m_cr2;
        3'd2: if (wr) begin if (tip) eer = 1'b1; else m_br = wd[7:0] & 8'h77; end else erd = m_br;
        3'd3: if (wr) begin if (wd[3]) m_ovf = 1'b0; end else erd = m_sr();
        3'd5: if (wr) begin
                if (tx_full) eer = 1'b1; else do_push = 1'b1;
              end else begin
                if (rx_empty) eer = 1'b1; else begin erd = rx_q[0]; rd_pop = 1'b1; end
              end
        default: eer = 1'b1;
      endcase
    end
    if (st && tx_q.size() > 0) void'(tx_q.pop_front());
    if (do_push) tx_q.push_back(wd);
    if (rd_pop) void'(rx_q.pop_front());
    if (sp) begin
      if (rx_q.size() < DEPTH) rx_q.push_back(sd);
      else if (IRQ_EN) m_ovf = 1'b1;
    end
  endfunction

  task automatic chk_outs(input string tag);
    logic [7:0] sr;
    sr = m_sr();
    chk({tag, "_txvalid"}, tx_valid, tx_q.size() != 0);
    if (tx_q.size() != 0) chk({tag, "_txdata"}, tx_data, tx_q[0]);
    chk({tag, "_cfg"}, {mstr, cpol, cpha, lsbfe, spe, spiswai, sppr, spr},
        {m_cr1[4], m_cr1[3], m_cr1[2], m_cr1[0], m_cr1[6], m_cr2[1], m_br[6:4], m_br[2:0]});
    chk({tag, "_irq"}, irq,
        IRQ_EN && ((m_cr1[7] && (sr[7] || sr[4] || sr[3])) || (m_cr1[5] && sr[5])));
  endtask

  typedef struct packed {
    logic       wr;
    logic [2:0] a;
    logic [7:0] wd;
    logic       tp;
    logic [7:0] rd;
    logic       er;
  } vec_t;

  vec_t vt [16];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rd, erd;
    logic er, eer;
    logic [7:0] exp_tx [4];

    vt[0]  = '{1'b0, 3'd0, 8'h00, 1'b0, 8'h04, 1'b0};
    vt[1]  = '{1'b0, 3'd1, 8'h00, 1'b0, 8'h00, 1'b0};
    vt[2]  = '{1'b0, 3'd2, 8'h00, 1'b0, 8'h00, 1'b0};
    vt[3]  = '{1'b0, 3'd3, 8'h00, 1'b0, 8'h24, 1'b0};
    vt[4]  = '{1'b0, 3'd4, 8'h00, 1'b0, 8'h00, 1'b1};
    vt[5]  = '{1'b1, 3'd7, 8'h12, 1'b0, 8'h00, 1'b1};
    vt[6]  = '{1'b1, 3'd1, 8'hFF, 1'b0, 8'h00, 1'b0};
    vt[7]  = '{1'b0, 3'd1, 8'h00, 1'b0, 8'h1B, 1'b0};
    vt[8]  = '{1'b1, 3'd2, 8'hFF, 1'b0, 8'h00, 1'b0};
    vt[9]  = '{1'b0, 3'd2, 8'h00, 1'b0, 8'h77, 1'b0};
    vt[10] = '{1'b1, 3'd0, 8'h50, 1'b1, 8'h00, 1'b1};
    vt[11] = '{1'b0, 3'd0, 8'h00, 1'b0, 8'h04, 1'b0};
    vt[12] = '{1'b0, 3'd5, 8'h00, 1'b0, 8'h00, 1'b1};
    vt[13] = '{1'b1, 3'd3, 8'h08, 1'b0, 8'h00, 1'b0};
    vt[14] = '{1'b0, 3'd3, 8'h00, 1'b0, 8'h24, 1'b0};
    vt[15] = '{1'b0, 3'd6, 8'h00, 1'b1, 8'h00, 1'b1};

    // Reset state
    repeat (3) @(posedge PClk);
    @(negedge PClk);
    PRESETn = 1'b1;
    @(negedge PClk);
    chk("rst_pready", PREADY, 0);
    chk("rst_pslverr", PSLVERR, 0);
    chk("rst_prdata", PRDATA, 0);
    chk("rst_txvalid", tx_valid, 0);
    chk("rst_irq", irq, 0);
    chk("rst_cfg", {mstr, cpol, cpha, lsbfe, spe, spiswai, sppr, spr}, 12'b0010_0000_0000);

    // Table-driven register vectors
    for (int i = 0; i < 16; i++) begin
      tip = vt[i].tp;
      apb(vt[i].wr, vt[i].a, vt[i].wd, 1'b0, 1'b0, '0, rd, er);
      tip = 1'b0;
      chk($sformatf("vec%0d_rd", i), rd, vt[i].rd);
      chk($sformatf("vec%0d_err", i), er, vt[i].er);
    end
    @(negedge PClk);
    chk("cfg_spiswai", spiswai, 1);
    chk("cfg_sppr", sppr, 7);
    chk("cfg_spr", spr, 7);
    chk("cfg_cpha", cpha, 1);
    apb_w("restore_cr2", 3'd1, 8'h00, 1'b0);
    apb_w("restore_br", 3'd2, 8'h00, 1'b0);

    // TX fill, overflow error, drain order
    exp_tx = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) apb_w($sformatf("tx_wr%0d", i), 3'd5, exp_tx[i], 1'b0);
    apb_r("tx_full_sr", 3'd3, 8'h00, 1'b0);
    apb_w("tx_wr_full", 3'd5, 8'h55, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge PClk);
      chk($sformatf("tx_valid%0d", i), tx_valid, 1);
      chk($sformatf("tx_data%0d", i), tx_data, exp_tx[i]);
      cyc(1'b0, 1'b1, '0);
    end
    @(negedge PClk);
    chk("tx_drained_valid", tx_valid, 0);
    cyc(1'b0, 1'b1, '0);
    apb_r("tx_empty_pop_sr", 3'd3, 8'h24, 1'b0);
    // Full TX write with simultaneous core pop is still an error
    for (int i = 0; i < 4; i++) apb_w($sformatf("tx2_wr%0d", i), 3'd5, 8'h61 + 8'(i), 1'b0);
    apb(1'b1, 3'd5, 8'h65, 1'b0, 1'b1, '0, rd, er);
    chk("tx_full_pop_err", er, 1);
    apb_r("tx_full_pop_sr", 3'd3, 8'h20, 1'b0);
    @(negedge PClk);
    chk("tx_full_pop_head", tx_data, 8'h62);
    repeat (3) cyc(1'b0, 1'b1, '0);

    // RX overflow, interrupt, reads, empty-read error, overflow clear
    apb_w("rx_cr1", 3'd0, 8'h84, 1'b0);
    repeat (5) cyc(1'b1, 1'b0, 8'hA5);
    apb_r("rx_ovf_sr", 3'd3, IRQ_EN ? 8'hAC : 8'hA4, 1'b0);
    @(negedge PClk);
    chk("rx_irq_full", irq, IRQ_EN);
    for (int i = 0; i < 4; i++) apb_r($sformatf("rx_rd%0d", i), 3'd5, 8'hA5, 1'b0);
    @(negedge PClk);
    chk("rx_irq_ovf_only", irq, IRQ_EN);
    apb_r("rx_rd_empty", 3'd5, 8'h00, 1'b1);
    apb_w("rx_clr", 3'd3, 8'h08, 1'b0);
    apb_r("rx_clr_sr", 3'd3, 8'h24, 1'b0);
    @(negedge PClk);
    chk("rx_irq_clr", irq, 0);
    // Empty read with same-cycle push: error, frame kept
    apb(1'b0, 3'd5, '0, 1'b1, 1'b0, 8'h3C, rd, er);
    chk("rx_empty_push_err", er, 1);
    chk("rx_empty_push_rd", rd, 0);
    apb_r("rx_kept", 3'd5, 8'h3C, 1'b0);
    // Full RX: push with a same-cycle DR read is accepted, no overflow
    for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b0, 8'(i));
    apb(1'b0, 3'd5, '0, 1'b1, 1'b0, 8'h05, rd, er);
    chk("rx_fullpop_rd", rd, 8'h01);
    chk("rx_fullpop_err", er, 0);
    apb_r("rx_fullpop_sr", 3'd3, 8'hA4, 1'b0);
    for (int i = 2; i <= 5; i++) apb_r($sformatf("rx_fp_rd%0d", i), 3'd5, 8'(i), 1'b0);

    // Mode fault
    apb_w("modf_cr1", 3'd0, 8'h10, 1'b0);
    apb_w("modf_cr2", 3'd1, 8'h10, 1'b0);
    SS = 1'b0;
    apb_r("modf_set", 3'd3, 8'h34, 1'b0);
    SS = 1'b1;
    apb_r("modf_ss_hi", 3'd3, 8'h24, 1'b0);
    apb_w("modf_ssoe", 3'd0, 8'h12, 1'b0);
    SS = 1'b0;
    apb_r("modf_ssoe_sr", 3'd3, 8'h24, 1'b0);
    SS = 1'b1;
    @(negedge PClk);
    chk("modf_mstr", mstr, 1);

    // Reset asserted in the ENABLE cycle of a DR write
    @(posedge PClk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 3'd5; PWDATA = 8'h99;
    @(posedge PClk); #1;
    PENABLE = 1'b1;
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 4 && !got; i++) begin
        @(negedge PClk);
        if (PREADY) got = 1'b1;
      end
      chk("rstmid_pready", got, 1);
    end
    PRESETn = 1'b0;
    @(posedge PClk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PClk);
    chk("rstmid_txvalid", tx_valid, 0);
    chk("rstmid_pready_low", PREADY, 0);
    chk("rstmid_cfg", {mstr, cpha}, 2'b01);
    PRESETn = 1'b1;
    apb_r("rstmid_sr", 3'd3, 8'h24, 1'b0);
    apb_r("rstmid_cr1", 3'd0, 8'h04, 1'b0);
    apb_r("rstmid_cr2", 3'd1, 8'h00, 1'b0);

    // Randomized phase against the transaction model
    m_reset();
    for (int n = 0; n < 400; n++) begin
      logic [2:0] addrs [12];
      logic sp, st, wr;
      logic [2:0] a;
      logic [DW-1:0] wd, sd;
      addrs = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd5, 3'd5, 3'd5, 3'd5, 3'd4, 3'd6, 3'd7};
      SS  = 1'($urandom_range(0, 1));
      tip = ($urandom_range(0, 3) == 0);
      sp  = ($urandom_range(0, 2) == 0);
      st  = ($urandom_range(0, 2) == 0);
      sd  = DW'($urandom);
      wd  = DW'($urandom);
      wr  = 1'($urandom_range(0, 1));
      a   = addrs[$urandom_range(0, 11)];
      if ($urandom_range(0, 9) < 3) begin
        cyc(sp, st, sd);
        m_step(1'b0, 1'b0, 3'd0, '0, sp, st, sd, erd, eer);
      end else begin
        m_step(1'b1, wr, a, wd, sp, st, sd, erd, eer);
        apb(wr, a, wd, sp, st, sd, rd, er);
        chk($sformatf("rnd%0d_rd", n), rd, erd);
        chk($sformatf("rnd%0d_err", n), er, eer);
      end
      tip = 1'b0;
      @(negedge PClk);
      chk_outs($sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
